// File: rtl/gameplay_pkg.sv
// rtl/gameplay_pkg.sv - shared constants, status codes and helpers for the gameplay block
package gameplay_pkg;

    localparam logic [7:0] X_INIT = 8'd0;
    localparam logic [7:0] X_END  = 8'd144;

    localparam logic GO_LEFT  = 1'b0;
    localparam logic GO_RIGHT = 1'b1;

    // Row y coordinates, bottom row first
    localparam logic [6:0] Y_ROW_0 = 7'd104;
    localparam logic [6:0] Y_ROW_1 = 7'd88;
    localparam logic [6:0] Y_ROW_2 = 7'd72;
    localparam logic [6:0] Y_ROW_3 = 7'd56;
    localparam logic [6:0] Y_ROW_4 = 7'd40;
    localparam logic [6:0] Y_ROW_5 = 7'd24;
    localparam logic [6:0] Y_ROW_6 = 7'd8;

    typedef enum logic [2:0] {
        GS_IDLE      = 3'd0,
        GS_MOVING    = 3'd1,
        GS_PLACED    = 3'd2,
        GS_MISSED    = 3'd3,
        GS_GAME_OVER = 3'd4,
        GS_WIN       = 3'd5
    } game_status_t;

    // Unsigned distance between two x coordinates, widened so it never wraps
    function automatic logic [8:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
        if (a >= b) begin
            return {1'b0, a} - {1'b0, b};
        end
        return {1'b0, b} - {1'b0, a};
    endfunction

endpackage

// File: rtl/gameplay_datapath_if.sv
// rtl/gameplay_datapath_if.sv - load/command strobes and position/counter outputs of the gameplay datapath
// master: control side (drives loads and commands, observes state)
// slave : datapath side (receives loads and commands, drives state)
interface gameplay_datapath_if;
    logic       ld_x;
    logic       ld_y;
    logic       ld_d;
    logic [7:0] new_x_position;
    logic [6:0] new_y_position;
    logic       new_direction;
    logic       enable;
    logic       save_x;
    logic       inc_score;
    logic       dec_chances;

    logic [7:0] x_position;
    logic [6:0] y_position;
    logic       direction;
    logic [7:0] prev_x;
    logic [7:0] score;
    logic [3:0] chances;
    logic       c;
    logic       o;

    modport master (
        output ld_x, ld_y, ld_d, new_x_position, new_y_position, new_direction,
        output enable, save_x, inc_score, dec_chances,
        input  x_position, y_position, direction, prev_x, score, chances, c, o
    );

    modport slave (
        input  ld_x, ld_y, ld_d, new_x_position, new_y_position, new_direction,
        input  enable, save_x, inc_score, dec_chances,
        output x_position, y_position, direction, prev_x, score, chances, c, o
    );
endinterface

// File: rtl/gameplay_datapath_rate_divider.sv
// rtl/gameplay_datapath_rate_divider.sv - enable-gated divide-by-DIV tick generator
// Ports: clk, resetn (async active-low), enable (count permit), clear (restart count),
//        tick (one cycle high when the DIV-th enabled cycle is reached)
module rate_divider #(
    parameter int DIV = 833333
) (
    input  logic clk,
    input  logic resetn,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // Combinational so the step lands on the same edge that wraps the counter
    assign tick = enable && (cnt == LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/gameplay_datapath.sv
// rtl/gameplay_datapath.sv - block position, bounce, score and chances datapath
// Ports: clk, resetn (async assert, clk-synchronised release),
//        gp (slave): ld_x/ld_y/ld_d + new_* load values, enable, save_x, inc_score, dec_chances in;
//        x_position, y_position, direction, prev_x, score, chances, c (chances left), o (overlap) out
module gameplay_datapath
    import gameplay_pkg::*;
#(
    parameter int SHIFT_DIV    = 833333,
    parameter int CHANCES_INIT = 10,
    parameter int BLOCK_W      = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    gameplay_datapath_if.slave   gp
);

    // Reset asserts immediately but is released only after two clk edges
    logic [1:0] rst_sync;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync[1];

    logic tick;

    rate_divider #(
        .DIV (SHIFT_DIV)
    ) u_rate_divider (
        .clk    (clk),
        .resetn (rst_int_n),
        .enable (gp.enable),
        .clear  (gp.ld_x),
        .tick   (tick)
    );

    logic [7:0] x_q;
    logic [6:0] y_q;
    logic       dir_q;
    logic [7:0] prev_q;
    logic [7:0] score_q;
    logic [3:0] chances_q;

    // A load wins over a step; the bounce belongs to the step, so it is suppressed too
    logic step;
    logic at_right;
    logic at_left;

    assign step     = tick && !gp.ld_x;
    assign at_right = (x_q >= X_END);
    assign at_left  = (x_q == X_INIT);

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            x_q       <= X_INIT;
            y_q       <= '0;
            dir_q     <= GO_RIGHT;
            prev_q    <= X_INIT;
            score_q   <= '0;
            chances_q <= 4'(CHANCES_INIT);
        end else begin
            if (gp.ld_x) begin
                x_q <= (gp.new_x_position > X_END) ? X_END : gp.new_x_position;
            end else if (step) begin
                if (dir_q == GO_RIGHT) begin
                    x_q <= at_right ? (X_END - 8'd1) : (x_q + 8'd1);
                end else begin
                    x_q <= at_left ? (X_INIT + 8'd1) : (x_q - 8'd1);
                end
            end

            if (gp.ld_d) begin
                dir_q <= gp.new_direction;
            end else if (step && (dir_q == GO_RIGHT) && at_right) begin
                dir_q <= GO_LEFT;
            end else if (step && (dir_q == GO_LEFT) && at_left) begin
                dir_q <= GO_RIGHT;
            end

            if (gp.ld_y) begin
                y_q <= gp.new_y_position;
            end

            // Captures x as it was before any same-cycle load
            if (gp.save_x) begin
                prev_q <= x_q;
            end

            if (gp.inc_score && (score_q != 8'hFF)) begin
                score_q <= score_q + 8'd1;
            end

            if (gp.dec_chances && (chances_q != 4'd0)) begin
                chances_q <= chances_q - 4'd1;
            end
        end
    end

    assign gp.x_position = x_q;
    assign gp.y_position = y_q;
    assign gp.direction  = dir_q;
    assign gp.prev_x     = prev_q;
    assign gp.score      = score_q;
    assign gp.chances    = chances_q;
    assign gp.c          = (chances_q != 4'd0);
    assign gp.o          = (abs_diff(x_q, prev_q) < 9'(BLOCK_W));

endmodule
